// File: rtl/dmem_if.sv
// Valid/ready data-memory bus between the load/store unit (master) and memory (slave).
// Requests carry a word-aligned address; read data returns on a separate response strobe.
interface dmem_if;
    logic        bus_valid;
    logic        bus_ready;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    modport master (
        output bus_valid,
        output bus_we,
        output bus_addr,
        output bus_be,
        output bus_wdata,
        input  bus_ready,
        input  bus_rvalid,
        input  bus_rdata
    );

    modport slave (
        input  bus_valid,
        input  bus_we,
        input  bus_addr,
        input  bus_be,
        input  bus_wdata,
        output bus_ready,
        output bus_rvalid,
        output bus_rdata
    );
endinterface

// File: rtl/dmem_lsu.sv
// Multicycle load/store unit: turns one rv32i load/store into a bus transaction, stalling
// the core until it completes, and returns the lane-extracted, extended load word.
module dmem_lsu #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_dm_rd,
    input  logic        i_dm_wr,
    input  logic [2:0]  i_dm_ctrl,
    input  logic [31:0] i_address,
    input  logic [31:0] i_store_data,
    output logic [31:0] o_data_rd,
    output logic        o_stall,
    output logic        o_misalign_err,
    output logic        o_bus_err,
    dmem_if.master      bus
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {StIdle, StReq, StWaitRsp, StDone} state_e;

    state_e      r_state;
    state_e      w_state_next;
    logic [CntW-1:0] r_cnt;
    logic        r_we;
    logic [31:0] r_bus_addr;
    logic [3:0]  r_bus_be;
    logic [31:0] r_bus_wdata;
    logic [1:0]  r_lane;
    logic        r_is_b;
    logic        r_is_h;
    logic        r_unsigned;
    logic [31:0] r_data_rd;
    logic        r_misalign_err;
    logic        r_bus_err;

    logic        w_req;
    logic        w_is_b;
    logic        w_is_h;
    logic        w_is_w;
    logic        w_misalign;
    logic        w_accept;
    logic        w_timeout;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;

    // Reserved funct3 encodings (x11, 110) fall through to word size.
    assign w_req      = i_dm_rd | i_dm_wr;
    assign w_is_b     = (i_dm_ctrl[1:0] == 2'b00);
    assign w_is_h     = (i_dm_ctrl[1:0] == 2'b01);
    assign w_is_w     = ~w_is_b & ~w_is_h;
    assign w_misalign = (w_is_h & i_address[0]) | (w_is_w & (|i_address[1:0]));
    assign w_accept   = (r_state == StIdle) & w_req & ~w_misalign;
    assign w_timeout  = (r_cnt == CntW'(TIMEOUT - 1));

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = i_store_data;
        if (w_is_b) begin
            w_be    = 4'b0001 << i_address[1:0];
            w_wdata = {4{i_store_data[7:0]}};
        end else if (w_is_h) begin
            w_be    = 4'b0011 << {i_address[1], 1'b0};
            w_wdata = {2{i_store_data[15:0]}};
        end
    end

    always_comb begin
        w_byte = 8'h00;
        unique case (r_lane)
            2'd0: w_byte = bus.bus_rdata[7:0];
            2'd1: w_byte = bus.bus_rdata[15:8];
            2'd2: w_byte = bus.bus_rdata[23:16];
            2'd3: w_byte = bus.bus_rdata[31:24];
        endcase
        w_half = r_lane[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
        if (r_is_b) begin
            w_load = {{24{~r_unsigned & w_byte[7]}}, w_byte};
        end else if (r_is_h) begin
            w_load = {{16{~r_unsigned & w_half[15]}}, w_half};
        end else begin
            w_load = bus.bus_rdata;
        end
    end

    // A request still visible in StDone is the retiring instruction, so it is not reissued.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:    if (w_accept) w_state_next = StReq;
            StReq:     if (bus.bus_ready) w_state_next = r_we ? StDone : StWaitRsp;
            StWaitRsp: if (bus.bus_rvalid || w_timeout) w_state_next = StDone;
            StDone:    w_state_next = StIdle;
            default:   w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt          <= '0;
            r_we           <= 1'b0;
            r_bus_addr     <= 32'h0;
            r_bus_be       <= 4'h0;
            r_bus_wdata    <= 32'h0;
            r_lane         <= 2'd0;
            r_is_b         <= 1'b0;
            r_is_h         <= 1'b0;
            r_unsigned     <= 1'b0;
            r_data_rd      <= 32'h0;
            r_misalign_err <= 1'b0;
            r_bus_err      <= 1'b0;
        end else begin
            r_misalign_err <= (r_state == StIdle) & w_req & w_misalign;
            r_bus_err      <= (r_state == StWaitRsp) & ~bus.bus_rvalid & w_timeout;
            if (w_accept) begin
                r_we        <= i_dm_wr;
                r_bus_addr  <= {i_address[31:2], 2'b00};
                r_bus_be    <= w_be;
                r_bus_wdata <= w_wdata;
                r_lane      <= i_address[1:0];
                r_is_b      <= w_is_b;
                r_is_h      <= w_is_h;
                r_unsigned  <= i_dm_ctrl[2];
            end
            if (r_state == StReq) begin
                r_cnt <= '0;
            end else if (r_state == StWaitRsp && !bus.bus_rvalid && !w_timeout) begin
                r_cnt <= r_cnt + CntW'(1);
            end
            if (r_state == StWaitRsp) begin
                if (bus.bus_rvalid) begin
                    r_data_rd <= w_load;
                end else if (w_timeout) begin
                    r_data_rd <= 32'h0;
                end
            end
        end
    end

    // Gated by rst_n so the core is never held while the unit is in reset.
    assign o_stall = rst_n & (w_accept | (r_state == StReq) | (r_state == StWaitRsp));

    assign o_data_rd      = r_data_rd;
    assign o_misalign_err = r_misalign_err;
    assign o_bus_err      = r_bus_err;

    assign bus.bus_valid = (r_state == StReq);
    assign bus.bus_we    = r_we;
    assign bus.bus_addr  = r_bus_addr;
    assign bus.bus_be    = r_bus_be;
    assign bus.bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: directed test-plan steps followed by random accesses, all checked
// against an arithmetic reference model of byte enables, lane replication and extension.
module tb_dmem_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dm_rd = 1'b0;
    logic        dm_wr = 1'b0;
    logic [2:0]  dm_ctrl = 3'd0;
    logic [31:0] address = 32'h0;
    logic [31:0] store_data = 32'h0;
    logic [31:0] data_rd;
    logic        stall;
    logic        misalign_err;
    logic        bus_err;

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [31:0] exp_data = 32'h0;

    dmem_if bus_if ();

    dmem_lsu #(.TIMEOUT(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_dm_rd        (dm_rd),
        .i_dm_wr        (dm_wr),
        .i_dm_ctrl      (dm_ctrl),
        .i_address      (address),
        .i_store_data   (store_data),
        .o_data_rd      (data_rd),
        .o_stall        (stall),
        .o_misalign_err (misalign_err),
        .o_bus_err      (bus_err),
        .bus            (bus_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic int unsigned nbytes(input logic [2:0] c);
        case (c[1:0])
            2'd0:    return 1;
            2'd1:    return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] c, input logic [31:0] a);
        int unsigned n = nbytes(c);
        if (n == 4) return 4'hF;
        return 4'((n == 1 ? 1 : 3) << (a % 4));
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] c, input logic [31:0] sd);
        int unsigned n = nbytes(c);
        if (n == 1) return (sd & 32'hFF) * 32'h01010101;
        if (n == 2) return (sd & 32'hFFFF) * 32'h00010001;
        return sd;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] c, input logic [31:0] a,
                                               input logic [31:0] word);
        int unsigned n = nbytes(c);
        logic [31:0] v = word >> (8 * (a % 4));
        if (n == 1) begin
            v = v & 32'hFF;
            if (!c[2] && v >= 32'h80) v = v - 32'h100;
        end else if (n == 2) begin
            v = v & 32'hFFFF;
            if (!c[2] && v >= 32'h8000) v = v - 32'h10000;
        end else begin
            v = word;
        end
        return v;
    endfunction

    // Entered and left at posedge+1 with the unit idle. The request is held until the
    // retiring cycle, as a stalled core would.
    task automatic access(input bit wr, input bit rd, input logic [2:0] c, input logic [31:0] a,
                          input logic [31:0] sd, input int rdy_dly, input bit give_rsp,
                          input int rsp_dly, input logic [31:0] rdata);
        bit mis;
        dm_wr = wr; dm_rd = rd; dm_ctrl = c; address = a; store_data = sd;
        #1;
        mis = (a % nbytes(c)) != 0;
        if (mis) begin
            chk("mis_stall", stall, 0);
            @(posedge clk); #1;
            chk("mis_pulse", misalign_err, 1);
            chk("mis_valid", bus_if.bus_valid, 0);
            chk("mis_stall_held", stall, 0);
            dm_wr = 0; dm_rd = 0;
            @(posedge clk); #1;
            chk("mis_pulse_end", misalign_err, 0);
            chk("mis_data_hold", data_rd, exp_data);
            return;
        end
        chk("acc_stall", stall, 1);
        @(posedge clk); #1;
        for (int i = 0; i <= rdy_dly; i++) begin
            chk("req_valid", bus_if.bus_valid, 1);
            chk("req_stall", stall, 1);
            chk("req_we", bus_if.bus_we, wr);
            chk("req_addr", bus_if.bus_addr, a & 32'hFFFF_FFFC);
            chk("req_be", bus_if.bus_be, model_be(c, a));
            if (wr) chk("req_wdata", bus_if.bus_wdata, model_wdata(c, sd));
            bus_if.bus_rvalid = 1'b1;
            bus_if.bus_rdata  = $urandom;
            bus_if.bus_ready  = (i == rdy_dly);
            @(posedge clk); #1;
        end
        bus_if.bus_ready  = 1'b0;
        bus_if.bus_rvalid = 1'b0;
        if (wr) begin
            chk("st_done_stall", stall, 0);
            chk("st_done_valid", bus_if.bus_valid, 0);
            chk("st_done_berr", bus_err, 0);
        end else begin
            chk("wait_valid", bus_if.bus_valid, 0);
            chk("wait_stall", stall, 1);
            if (give_rsp) begin
                for (int i = 0; i < rsp_dly; i++) begin
                    @(posedge clk); #1;
                    chk("wait_stall_loop", stall, 1);
                end
                bus_if.bus_rvalid = 1'b1;
                bus_if.bus_rdata  = rdata;
                @(posedge clk); #1;
                bus_if.bus_rvalid = 1'b0;
                exp_data = model_load(c, a, rdata);
                chk("ld_data", data_rd, exp_data);
                chk("ld_done_stall", stall, 0);
                chk("ld_done_berr", bus_err, 0);
            end else begin
                for (int i = 0; i < 16; i++) begin
                    chk("to_stall", stall, 1);
                    chk("to_berr_early", bus_err, 0);
                    @(posedge clk); #1;
                end
                exp_data = 32'h0;
                chk("to_berr", bus_err, 1);
                chk("to_data", data_rd, 0);
                chk("to_stall_end", stall, 0);
            end
        end
        dm_wr = 0; dm_rd = 0;
        @(posedge clk); #1;
        chk("idle_berr", bus_err, 0);
        chk("idle_stall", stall, 0);
        chk("idle_valid", bus_if.bus_valid, 0);
        chk("idle_data_hold", data_rd, exp_data);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit wr;
        bit rd;
        bus_if.bus_ready  = 1'b0;
        bus_if.bus_rvalid = 1'b0;
        bus_if.bus_rdata  = 32'h0;

        // Reset with an aligned load pending: nothing may leak out, Stall stays low.
        dm_rd = 1; dm_ctrl = 3'b010; address = 32'h100;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_valid", bus_if.bus_valid, 0);
        chk("rst_data", data_rd, 0);
        chk("rst_we", bus_if.bus_we, 0);
        chk("rst_addr", bus_if.bus_addr, 0);
        chk("rst_be", bus_if.bus_be, 0);
        chk("rst_wdata", bus_if.bus_wdata, 0);
        chk("rst_mis", misalign_err, 0);
        chk("rst_berr", bus_err, 0);
        dm_rd = 0;
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
        chk("post_rst_stall", stall, 0);
        chk("post_rst_valid", bus_if.bus_valid, 0);

        // Directed test-plan steps, with independently written constants.
        access(1, 0, 3'b000, 32'h1003, 32'h0000_00AB, 2, 0, 0, 32'h0);
        access(0, 1, 3'b000, 32'h2001, 32'h0, 0, 1, 3, 32'hDEAD_80EF);
        chk("lb_const", data_rd, 32'hFFFF_FF80);
        access(0, 1, 3'b100, 32'h2001, 32'h0, 1, 1, 3, 32'hDEAD_80EF);
        chk("lbu_const", data_rd, 32'h0000_0080);
        access(0, 1, 3'b001, 32'h2002, 32'h0, 0, 1, 3, 32'hCAFE_BABE);
        chk("lh_const", data_rd, 32'hFFFF_CAFE);
        access(0, 1, 3'b010, 32'h2000, 32'h0, 0, 1, 15, 32'hCAFE_BABE);
        chk("lw_const", data_rd, 32'hCAFE_BABE);
        access(0, 1, 3'b010, 32'h2002, 32'h0, 0, 1, 0, 32'h0);
        chk("mis_lw_data_hold", data_rd, 32'hCAFE_BABE);
        access(1, 1, 3'b001, 32'h3006, 32'h1234_5678, 0, 0, 0, 32'h0);
        access(0, 1, 3'b010, 32'h4000, 32'h0, 0, 0, 0, 32'h0);
        chk("timeout_const", data_rd, 32'h0);

        // Reset while waiting for a response aborts the load on the spot.
        access(0, 1, 3'b010, 32'h5000, 32'h0, 0, 1, 1, 32'h5555_AAAA);
        dm_rd = 1; dm_ctrl = 3'b010; address = 32'h6000;
        @(posedge clk); #1;
        bus_if.bus_ready = 1'b1;
        @(posedge clk); #1;
        bus_if.bus_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_pre_stall", stall, 1);
        rst_n = 0;
        #1;
        exp_data = 32'h0;
        chk("midrst_valid", bus_if.bus_valid, 0);
        chk("midrst_stall", stall, 0);
        chk("midrst_data", data_rd, 0);
        chk("midrst_berr", bus_err, 0);
        dm_rd = 0;
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
        chk("midrst_idle_stall", stall, 0);
        chk("midrst_idle_valid", bus_if.bus_valid, 0);

        // Random accesses, including reserved funct3 codes treated as word.
        for (int n = 0; n < 40; n++) begin
            wr = 1'($urandom_range(0, 1));
            rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
            access(wr, rd, 3'($urandom_range(0, 7)), $urandom, $urandom,
                   $urandom_range(0, 3), ($urandom_range(0, 7) != 0),
                   $urandom_range(0, 15), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Multicycle load/store unit between the rv32i datapath and a valid/ready data-memory bus.
- Produces the `DataRd` word consumed by the writeback select stage.
- Generates byte enables and lane-replicated store data; sign/zero-extends loads.
- Holds the core with `Stall` until the bus transaction completes.

Parameters:
- TIMEOUT, 16, max cycles waited in WAIT_RSP before aborting a load with `BusErr`.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- DMRd  input  1  load request from current instruction
- DMWr  input  1  store request from current instruction
- DMCtrl  input  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- Address  input  32  effective address (ALU result)
- StoreData  input  32  rs2 value
- DataRd  output  32  extended load result
- Stall  output  1  core must hold PC/pipeline regs
- MisalignErr  output  1  one-cycle pulse, misaligned access rejected
- BusErr  output  1  one-cycle pulse (in DONE), load timed out
- BusValid  output  1  request valid
- BusReady  input  1  memory accepts request
- BusWe  output  1  1 = write
- BusAddr  output  32  word-aligned address, {Address[31:2],2'b00}
- BusBe  output  4  byte enables
- BusWData  output  32  lane-replicated store data
- BusRValid  input  1  read response valid
- BusRData  input  32  read response word

Behaviour:
- Reset (async, rst_n=0): state IDLE; DataRd=0, BusValid=0, BusWe=0, BusAddr=0, BusBe=0, BusWData=0, MisalignErr=0, BusErr=0, timeout counter 0. Stall=0 while in reset. Reset mid-transaction aborts immediately; BusValid drops with no handshake.
- States: IDLE, REQ, WAIT_RSP, DONE.
- IDLE:
  - If DMWr or DMRd: check alignment. DMWr has priority when both are high (treated as a store).
  - Misaligned cases: H/HU with Address[0]=1; W with Address[1:0]≠0. These pulse MisalignErr next cycle, issue no bus request, assert no Stall, and stay in IDLE.
  - Aligned: latch op, size, Address[1:0], BusAddr, BusBe, BusWData; go to REQ.
  - Stall is asserted combinationally in this same cycle.
- Stall (combinational): 1 when (IDLE and aligned request present), or state is REQ or WAIT_RSP. 0 in DONE.
- REQ:
  - BusValid=1 and outputs held stable until BusReady.
  - On BusValid&BusReady: a write goes to DONE; a read goes to WAIT_RSP with counter cleared.
  - BusRValid is ignored in REQ.
- WAIT_RSP:
  - BusValid=0.
  - On BusRValid: capture BusRData, extract lane, extend, write DataRd; go to DONE.
  - Otherwise counter increments. When it reaches TIMEOUT−1 without BusRValid: DataRd=0, go to DONE, BusErr=1 during DONE.
- DONE: one cycle, Stall=0 so the core retires. Go to IDLE unconditionally; a request seen in DONE is the same instruction and is ignored.
- DataRd holds its value until the next completed load.
- Byte enables:
  - B: 4'b0001<<Address[1:0]
  - H: 4'b0011<<{Address[1],1'b0}
  - W: 4'b1111
- Store data:
  - B: {4{StoreData[7:0]}}
  - H: {2{StoreData[15:0]}}
  - W: StoreData
- Load extract: byte lane = Address[1:0]; half lane = Address[1]. B/H sign-extend; BU/HU zero-extend; W passes through.
- Reserved DMCtrl codes (011, 110, 111): treated as W.

Test Plan:
- Reset: rst_n=0 then release → all outputs 0, Stall=0, BusValid=0.
- Store SB: DMWr=1, DMCtrl=000, Address=0x1003, StoreData=0x000000AB, BusReady after 2 cycles → BusAddr=0x1000, BusBe=1000, BusWData=0xABABABAB, Stall high 3 cycles then DONE.
- Load LB/LBU: Address=0x2001, BusRData=0xDEAD80EF, BusRValid 3 cycles after accept → LB gives DataRd=0xFFFFFF80; LBU gives DataRd=0x00000080.
- Load LH: Address=0x2002, BusRData=0xCAFEBABE → DataRd=0xFFFFCAFE; LW at 0x2000 → DataRd=0xCAFEBABE.
- Misaligned LW at 0x2002 → MisalignErr pulse, BusValid never asserted, Stall=0.
- TIMEOUT=16, load accepted, no BusRValid → BusErr pulse after 16 cycles, DataRd=0, Stall deasserts. Repeat with rst_n pulsed while in WAIT_RSP → state IDLE, BusValid=0 immediately.
